// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with 16x oversampling, start/stop validation
module uart_receiver #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600,
    parameter int OVS      = 16,
    parameter int DIV      = CLK_FREQ / (BAUD * OVS)
) (
    input  logic       clk_i,
    input  logic       rstb_i,
    input  logic       rxd,
    output logic [7:0] data_o,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state, state_next;
    logic [1:0]    sync_q;
    logic          rxs;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    sample_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          done_set;
    logic          err_set;
    logic          mid_tick;
    logic          end_tick;

    assign rxs      = sync_q[1];
    assign tick     = (tick_cnt == CW'(DIV - 1));
    assign mid_tick = tick && (sample_cnt == 4'd7);
    assign end_tick = tick && (sample_cnt == 4'd15);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    // Held at zero while idle so the first tick lands DIV clocks after the start edge
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            tick_cnt <= '0;
        end else if (state == S_IDLE || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_set   = 1'b0;
        err_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs) state_next = S_START;
            end
            S_START: begin
                if (mid_tick) state_next = rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (end_tick && bit_idx == 3'd7) state_next = S_STOP;
            end
            S_STOP: begin
                if (end_tick) begin
                    if (rxs) begin
                        done_set   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        err_set    = 1'b1;
                        state_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rxs) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Restarting sample_cnt at mid start bit puts every later 16th tick at a bit centre
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            sample_cnt <= 4'd0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'h00;
        end else begin
            if (state == S_IDLE || state != state_next) begin
                sample_cnt <= 4'd0;
            end else if (tick) begin
                sample_cnt <= sample_cnt + 4'd1;
            end
            if (state == S_START) begin
                bit_idx <= 3'd0;
            end else if (state == S_DATA && end_tick) begin
                bit_idx   <= bit_idx + 3'd1;
                shift_reg <= {rxs, shift_reg[7:1]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            data_o    <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= done_set;
            frame_err <= err_set;
            if (done_set) data_o <= shift_reg;
        end
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Receive-side counterpart of the UART transmitter. It consumes the serial line (8N1, LSB first, idle high) and delivers one parallel byte per frame with a single-cycle valid pulse. It oversamples the line 16x using its own internal tick divider and validates start and stop bits. It sits directly downstream of the transmitter's txd pin, either on the board or in loopback.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD, 9600, line bit rate.
OVS, 16, oversampling ticks per bit; fixed at 16, not user-tuned.
DIV, CLK_FREQ/(BAUD*OVS), clocks per oversample tick (integer division; 651 at defaults); must be >= 2.

Ports:
clk_i  input  1  system clock, rising edge.
rstb_i  input  1  asynchronous, active-low reset.
rxd  input  1  serial line, asynchronous to clk_i, idle high.
data_o  output  8  last correctly received byte.
rx_done  output  1  one-cycle pulse; data_o is valid and updated in the same cycle.
frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
busy  output  1  high from start-bit detection until the FSM returns to IDLE.

Behaviour:
- Reset: one clock (clk_i); reset is asynchronous and active-low (rstb_i).
  - Effect of rstb_i=0: data_o=8'h00, rx_done=0, frame_err=0, busy=0.
  - Internally: FSM=IDLE, synchroniser flops=1, all counters=0.
  - Reset may assert at any point mid-frame. The partial frame is discarded and no pulse is emitted.
- Synchroniser: rxd passes through 2 flops, reset value 1. All decisions use the synchronised signal rxs.
- Tick generator: counter 0..DIV-1. Tick is high for one clk when the counter equals DIV-1, then the counter wraps to 0. The counter is forced to 0 when the FSM leaves IDLE, so ticks are phase-aligned to the start edge.
- Internal counters: sample_cnt (4 bits, counts ticks within a bit) and bit_idx (3 bits).
- IDLE:
  - busy=0.
  - rxs==0 -> START, with sample_cnt=0 and busy=1.
- START:
  - On the 8th tick (mid start bit), if rxs==0 -> DATA, with sample_cnt=0 and bit_idx=0.
  - If rxs==1 -> glitch: go to IDLE, no pulse.
- DATA:
  - On the 16th tick of each bit, shift rxs into shift_reg[7] and shift right (LSB first).
  - After bit_idx==7 is sampled -> STOP.
- STOP:
  - On the 16th tick, if rxs==1: data_o<=shift_reg, rx_done=1 for that single cycle, go to IDLE.
  - If rxs==0: frame_err=1 for one cycle, data_o unchanged -> BREAK.
- BREAK:
  - busy stays 1.
  - Wait for rxs==1, then IDLE. This prevents a held-low line from retriggering a start.
- Latency: rx_done fires 8+8*16+16=152 ticks after the start-bit tick-counter reset, plus 2 clk of synchroniser delay measured from the rxd falling edge.
- Back-to-back frames: IDLE is re-entered mid stop bit. The next start edge is accepted with no idle gap required.
- rx_done and frame_err are mutually exclusive and never asserted in consecutive cycles for one frame.

Test Plan:
Bench uses CLK_FREQ=1600000, BAUD=10000, giving DIV=10 and 160 clk per bit.
1. Reset: hold rstb_i=0 with rxd=1, release -> data_o=8'h00, rx_done=0, frame_err=0, busy=0; then 2000 idle clk -> no pulses.
2. Frame 8'hA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop=1) -> exactly one rx_done pulse; data_o=8'hA5; pulse arrives 1522±10 clk after the rxd falling edge.
3. Glitch: rxd low for 40 clk, then high -> busy pulses briefly and returns to 0; no rx_done, no frame_err; a following 8'h3C frame is received correctly.
4. Framing error: after 3, send 8'h77 with stop=0, holding rxd low for 3 more bit times -> one frame_err pulse; data_o stays 8'h3C; busy=1 until rxd returns high; the next 8'h11 frame gives rx_done with 8'h11.
5. Back-to-back 8'h00 then 8'hFF with zero idle bits -> two rx_done pulses with data_o=8'h00 then 8'hFF; no frame_err.
6. Reset mid-frame: assert rstb_i=0 during bit 4 of 8'hC3 -> outputs go to reset values immediately with no pulse; after release and line idle, frame 8'h5A -> rx_done with data_o=8'h5A.
